// File: rtl/pool_a2_cu.sv
`default_nettype none
// ============================================================================
// Module   : pool_a2_cu
// Purpose  : 2x2 max-pool control unit: window-ordered reads, compare enables,
//            pooled-result writes and ping-pong handshaking with neighbours.
// Revision : 1.0 - initial release
// ============================================================================
module pool_a2_cu #(
    parameter int DATA_WIDTH            = 32,
    parameter int IFM_SIZE              = 28,
    parameter int IFM_DEPTH             = 6,
    parameter int READ_LATENCY          = 1,
    parameter int POOL_LATENCY          = 1,
    parameter int IFM_SIZE_NEXT         = IFM_SIZE / 2,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_from_previous,
    input  logic                             end_from_next,
    output logic                             end_to_previous,
    output logic                             ifm_sel_current,
    output logic                             ifm_enable_read_current,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
    output logic                             pool_load,
    output logic                             pool_enable,
    output logic                             ifm_enable_write_next,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
    output logic                             ifm_sel_next,
    output logic                             start_to_next,
    output logic                             ready
);

    localparam int AW    = ADDRESS_SIZE_IFM;
    localparam int AWN   = ADDRESS_SIZE_NEXT_IFM;
    localparam int CNT_W = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IFM_SIZE_NEXT - 1);
    localparam logic [AWN-1:0]   WR_LAST  = AWN'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);

    if ((IFM_SIZE % 2) != 0 || IFM_SIZE < 2 || READ_LATENCY < 1 || POOL_LATENCY < 1 ||
        DATA_WIDTH < 1 || IFM_DEPTH < 1) begin : g_bad_params
        $error("pool_a2_cu: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_DRAIN   = 2'd2,
        S_HANDOFF = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [1:0]                         r_w;
    logic [CNT_W-1:0]                   r_c;
    logic [CNT_W-1:0]                   r_r;
    // Tag bits: [2] valid, [1] first element of window, [0] last element
    logic [READ_LATENCY-1:0][2:0]       r_tag;
    logic [POOL_LATENCY-1:0]            r_wr;
    logic [AWN-1:0]                     r_wr_addr;
    logic                               r_sel_cur;
    logic                               r_sel_next;

    logic [2:0] w_tag_in;
    logic [2:0] w_tag_out;
    logic       w_last_read;
    logic       w_pipe_busy;
    logic       w_handoff;

    assign w_last_read = (r_state == S_READ) && (r_w == 2'd3) &&
                         (r_c == CNT_LAST) && (r_r == CNT_LAST);
    assign w_tag_in    = (r_state == S_READ) ? {1'b1, r_w == 2'd0, r_w == 2'd3} : 3'b000;
    assign w_tag_out   = r_tag[READ_LATENCY-1];
    assign w_handoff   = (r_state == S_HANDOFF) && end_from_next;

    always_comb begin
        w_pipe_busy = |r_wr;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_pipe_busy = w_pipe_busy | r_tag[i][2];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start_from_previous) w_state_next = S_READ;
            S_READ:    if (w_last_read)         w_state_next = S_DRAIN;
            S_DRAIN:   if (!w_pipe_busy)        w_state_next = S_HANDOFF;
            S_HANDOFF: if (end_from_next)       w_state_next = S_IDLE;
            default:                            w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_w        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_tag      <= '0;
            r_wr       <= '0;
            r_wr_addr  <= '0;
            r_sel_cur  <= 1'b0;
            r_sel_next <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Counters wrap to zero on the final read, ready for the next map
            if (r_state == S_READ) begin
                r_w <= r_w + 2'd1;
                if (r_w == 2'd3) begin
                    if (r_c == CNT_LAST) begin
                        r_c <= '0;
                        r_r <= (r_r == CNT_LAST) ? '0 : r_r + CNT_W'(1);
                    end else begin
                        r_c <= r_c + CNT_W'(1);
                    end
                end
            end

            r_tag[0] <= w_tag_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end

            r_wr[0] <= w_tag_out[2] & w_tag_out[0];
            for (int i = 1; i < POOL_LATENCY; i++) begin
                r_wr[i] <= r_wr[i-1];
            end

            if (r_wr[POOL_LATENCY-1]) begin
                r_wr_addr <= (r_wr_addr == WR_LAST) ? '0 : r_wr_addr + AWN'(1);
            end

            if (w_last_read) r_sel_cur  <= ~r_sel_cur;
            if (w_handoff)   r_sel_next <= ~r_sel_next;
        end
    end

    // Row index = 2r + w[1], column index = 2c + w[0], formed by concatenation
    assign ifm_address_read_current = AW'({r_r, r_w[1]}) * AW'(IFM_SIZE) + AW'({r_c, r_w[0]});

    assign ready                   = (r_state == S_IDLE);
    assign end_to_previous         = (r_state == S_IDLE);
    assign ifm_enable_read_current = (r_state == S_READ);
    assign ifm_sel_current         = r_sel_cur;
    assign pool_enable             = w_tag_out[2];
    assign pool_load               = w_tag_out[2] & w_tag_out[1];
    assign ifm_enable_write_next   = r_wr[POOL_LATENCY-1];
    assign ifm_address_write_next  = r_wr_addr;
    assign ifm_sel_next            = r_sel_next;
    assign start_to_next           = w_handoff;

endmodule
`default_nettype wire

// File: tb/tb_pool_a2_cu.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_a2_cu
// Purpose  : Scoreboard bench for pool_a2_cu with a window-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_a2_cu;

    localparam int IFM = 28;
    localparam int RL  = 1;
    localparam int PL  = 1;
    localparam int HN  = IFM / 2;
    localparam int N   = IFM * IFM;
    localparam int AW  = $clog2(N);
    localparam int AWN = $clog2(HN * HN);

    logic           clk = 1'b0;
    logic           reset;
    logic           start_from_previous;
    logic           end_from_next;
    logic           end_to_previous;
    logic           ifm_sel_current;
    logic           ifm_enable_read_current;
    logic [AW-1:0]  ifm_address_read_current;
    logic           pool_load;
    logic           pool_enable;
    logic           ifm_enable_write_next;
    logic [AWN-1:0] ifm_address_write_next;
    logic           ifm_sel_next;
    logic           start_to_next;
    logic           ready;

    pool_a2_cu #(
        .DATA_WIDTH  (32),
        .IFM_SIZE    (IFM),
        .IFM_DEPTH   (6),
        .READ_LATENCY(RL),
        .POOL_LATENCY(PL)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .start_from_previous     (start_from_previous),
        .end_from_next           (end_from_next),
        .end_to_previous         (end_to_previous),
        .ifm_sel_current         (ifm_sel_current),
        .ifm_enable_read_current (ifm_enable_read_current),
        .ifm_address_read_current(ifm_address_read_current),
        .pool_load               (pool_load),
        .pool_enable             (pool_enable),
        .ifm_enable_write_next   (ifm_enable_write_next),
        .ifm_address_write_next  (ifm_address_write_next),
        .ifm_sel_next            (ifm_sel_next),
        .start_to_next           (start_to_next),
        .ready                   (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
        bit last;
    } exp_t;

    // Channel 0: reads (addr), 1: pool_enable (load), 2: writes (addr)
    exp_t q[3][$];
    int   total = 0;
    int   bad   = 0;
    bit   map_active   = 1'b0;
    int   hand_earliest = 0;
    int   reads_this_map = 0;
    bit   exp_sel_cur  = 1'b0;
    bit   exp_sel_next = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic check_chan(input int ch, input string name, input logic act,
                              input logic [31:0] val);
        bit exp_act;
        while (q[ch].size() > 0 && q[ch][0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL %s missing: got nothing expected value %0d at cycle %0d",
                     name, q[ch][0].val, q[ch][0].cyc);
            void'(q[ch].pop_front());
        end
        exp_act = (q[ch].size() > 0) && (q[ch][0].cyc == cyc);
        chk({name, "_strobe"}, {31'd0, act}, {31'd0, exp_act});
        if (exp_act) begin
            if (act === 1'b1) chk({name, "_value"}, val, q[ch][0].val);
            if (ch == 0) begin
                reads_this_map++;
                if (q[0][0].last) exp_sel_cur = ~exp_sel_cur;
            end
            void'(q[ch].pop_front());
        end
    endtask

    // Reference: walk the 2x2 windows of the map in raster order
    task automatic push_map(input int s);
        exp_t e;
        int   k = 0;
        for (int rr = 0; rr < HN; rr++)
            for (int cc = 0; cc < HN; cc++)
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++) begin
                        e.cyc = s + 1 + k;
                        e.val = (2 * rr + dy) * IFM + 2 * cc + dx;
                        e.last = (k == N - 1);
                        q[0].push_back(e);
                        e.cyc = s + 1 + k + RL;
                        e.val = (dy == 0 && dx == 0) ? 1 : 0;
                        e.last = 1'b0;
                        q[1].push_back(e);
                        if (dy == 1 && dx == 1) begin
                            e.cyc = s + 1 + k + RL + PL;
                            e.val = rr * HN + cc;
                            q[2].push_back(e);
                        end
                        k++;
                    end
        hand_earliest = s + N + RL + PL + 2;
    endtask

    always @(negedge clk) begin
        bit exp_stn;
        chk("ready", {31'd0, ready}, {31'd0, !map_active});
        chk("end_to_previous", {31'd0, end_to_previous}, {31'd0, !map_active});
        chk("sel_current", {31'd0, ifm_sel_current}, {31'd0, exp_sel_cur});
        chk("sel_next", {31'd0, ifm_sel_next}, {31'd0, exp_sel_next});
        check_chan(0, "read", ifm_enable_read_current, {{(32-AW){1'b0}}, ifm_address_read_current});
        check_chan(1, "pool", pool_enable, {31'd0, pool_load});
        check_chan(2, "write", ifm_enable_write_next, {{(32-AWN){1'b0}}, ifm_address_write_next});
        chk("load_without_enable", {31'd0, pool_load & ~pool_enable}, 32'd0);
        exp_stn = map_active && (cyc >= hand_earliest) && (end_from_next === 1'b1);
        chk("start_to_next", {31'd0, start_to_next}, {31'd0, exp_stn});
        if (!map_active && reset === 1'b1 && start_from_previous === 1'b1) begin
            map_active     = 1'b1;
            reads_this_map = 0;
            push_map(cyc);
        end else if (exp_stn) begin
            chk("reads_per_map", reads_this_map, N);
            map_active   = 1'b0;
            exp_sel_next = ~exp_sel_next;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_end_to_previous"}, {31'd0, end_to_previous}, 32'd1);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_sel_current"}, {31'd0, ifm_sel_current}, 32'd0);
        chk({tag, "_read_en"}, {31'd0, ifm_enable_read_current}, 32'd0);
        chk({tag, "_read_addr"}, {{(32-AW){1'b0}}, ifm_address_read_current}, 32'd0);
        chk({tag, "_pool_load"}, {31'd0, pool_load}, 32'd0);
        chk({tag, "_pool_enable"}, {31'd0, pool_enable}, 32'd0);
        chk({tag, "_write_en"}, {31'd0, ifm_enable_write_next}, 32'd0);
        chk({tag, "_write_addr"}, {{(32-AWN){1'b0}}, ifm_address_write_next}, 32'd0);
        chk({tag, "_sel_next"}, {31'd0, ifm_sel_next}, 32'd0);
        chk({tag, "_start_to_next"}, {31'd0, start_to_next}, 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((map_active || q[0].size() > 0 || q[1].size() > 0 || q[2].size() > 0) && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    initial begin
        reset               = 1'b0;
        start_from_previous = 1'b0;
        end_from_next       = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        #1;
        check_idle("reset");
        step();

        // Directed map: downstream held busy, spurious start while reading
        start_from_previous = 1'b1;
        step();
        start_from_previous = 1'b0;
        repeat (99) step();
        start_from_previous = 1'b1;
        step();
        start_from_previous = 1'b0;
        for (int n = 0; n < 3000 && cyc < hand_earliest + 20; n++) step();
        end_from_next = 1'b1;
        wait_idle();

        // Back-to-back map reads the other ping-pong half
        start_from_previous = 1'b1;
        step();
        start_from_previous = 1'b0;
        wait_idle();

        // Randomized start pulses and downstream availability
        for (int i = 0; i < 4000; i++) begin
            start_from_previous = ($urandom_range(0, 15) == 0);
            end_from_next       = ($urandom_range(0, 3) == 0);
            step();
        end
        start_from_previous = 1'b0;
        end_from_next       = 1'b1;
        wait_idle();

        // Reset in the middle of a map, then a fresh map
        end_from_next       = 1'b0;
        start_from_previous = 1'b1;
        step();
        start_from_previous = 1'b0;
        repeat (299) step();
        reset = 1'b0;
        for (int ch = 0; ch < 3; ch++) q[ch].delete();
        map_active   = 1'b0;
        exp_sel_cur  = 1'b0;
        exp_sel_next = 1'b0;
        #1;
        check_idle("mid_reset");
        step();
        step();
        reset = 1'b1;
        step();
        start_from_previous = 1'b1;
        end_from_next       = 1'b1;
        step();
        start_from_previous = 1'b0;
        wait_idle();

        chk("queues_empty", q[0].size() + q[1].size() + q[2].size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
